axis_rr_arbiter: RTL and testbench

//   Packet-level round-robin arbiter sharing one AXI-Stream master port between NUM_SRC
//   AXI-Stream slave ports. A grant is held from the first beat to the tlast handshake,
//   so packets are never interleaved. Sits between upstream packet producers (DMA

---
 rtl/axis_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_arbiter
// Description : Packet-level round-robin arbiter. Shares one AXI-Stream master
//               port between NUM_SRC AXI-Stream slave ports. A grant is taken
//               in IDLE, held from the first beat to the tlast handshake
//               (PASS), and released with one bubble cycle between packets.
//               Packets are never interleaved.
// Ports       : aclk, aresetn (async, active-low)
//               s_tvalid/s_tready/s_tlast        [NUM_SRC]  per-source handshake
//               s_tdata/s_tstrb/s_tkeep/s_tid/
//               s_tdest/s_tuser                  flattened, source i at [i*W +: W]
//               m_t*                             single master stream
//               grant_valid                      high while a packet is locked
//               grant_idx                        index of locked source
// Config      : AXIS_ARB_TID_TAG_EN - when defined, m_tid carries the
//               zero-extended grant index instead of the source tid.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int TDATA_BYTES = 4,
    parameter int TID_BITS    = 2,
    parameter int TDEST_BITS  = 1,
    parameter int TUSER_BITS  = 1
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [NUM_SRC-1:0]                   s_tvalid,
    output logic [NUM_SRC-1:0]                   s_tready,
    input  logic [NUM_SRC*TDATA_BYTES*8-1:0]     s_tdata,
    input  logic [NUM_SRC*TDATA_BYTES-1:0]       s_tstrb,
    input  logic [NUM_SRC*TDATA_BYTES-1:0]       s_tkeep,
    input  logic [NUM_SRC-1:0]                   s_tlast,
    input  logic [NUM_SRC*TID_BITS-1:0]          s_tid,
    input  logic [NUM_SRC*TDEST_BITS-1:0]        s_tdest,
    input  logic [NUM_SRC*TUSER_BITS-1:0]        s_tuser,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [TDATA_BYTES*8-1:0]             m_tdata,
    output logic [TDATA_BYTES-1:0]               m_tstrb,
    output logic [TDATA_BYTES-1:0]               m_tkeep,
    output logic                                 m_tlast,
    output logic [TID_BITS-1:0]                  m_tid,
    output logic [TDEST_BITS-1:0]                m_tdest,
    output logic [TUSER_BITS-1:0]                m_tuser,
    output logic                                 grant_valid,
    output logic [$clog2(NUM_SRC)-1:0]           grant_idx
);

    localparam int c_IDX_W = $clog2(NUM_SRC);
    localparam int c_SUM_W = c_IDX_W + 1;
    localparam int c_DW    = TDATA_BYTES * 8;
    localparam int c_BW    = TDATA_BYTES;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PASS = 1'b1;

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_grant_idx;

    logic               w_found;
    logic [c_IDX_W-1:0] w_sel;
    logic [c_IDX_W-1:0] w_next_ptr;
    logic [TID_BITS-1:0] w_src_tid;

`ifdef AXIS_ARB_TID_TAG_EN
    generate
        if (TID_BITS < $clog2(NUM_SRC)) begin : g_tid_width_err
            $error("axis_rr_arbiter: TID_BITS too narrow to carry the grant index");
        end
    endgenerate
`endif

    // Circular search: first requesting source at or after the rr pointer.
    // The sum is kept one bit wider so the wrap works for non-power-of-2 counts.
    always_comb begin
        logic [c_SUM_W-1:0] v_idx;
        w_found = 1'b0;
        w_sel   = '0;
        v_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_idx = {1'b0, r_ptr} + c_SUM_W'(k);
            if (v_idx >= c_SUM_W'(NUM_SRC)) begin
                v_idx = v_idx - c_SUM_W'(NUM_SRC);
            end
            if (!w_found && s_tvalid[v_idx[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_idx[c_IDX_W-1:0];
            end
        end
    end

    // Pointer moves to the source after the one that just finished.
    always_comb begin
        logic [c_SUM_W-1:0] v_nxt;
        v_nxt = {1'b0, r_grant_idx} + c_SUM_W'(1);
        if (v_nxt >= c_SUM_W'(NUM_SRC)) begin
            v_nxt = '0;
        end
        w_next_ptr = v_nxt[c_IDX_W-1:0];
    end

    // Datapath mux. Everything is gated by the registered state, so m_tvalid
    // never depends on m_tready and all payload reads zero outside PASS.
    always_comb begin
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tstrb   = '0;
        m_tkeep   = '0;
        m_tlast   = 1'b0;
        m_tdest   = '0;
        m_tuser   = '0;
        w_src_tid = '0;
        s_tready  = '0;
        if (r_state == c_PASS) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (r_grant_idx == c_IDX_W'(i)) begin
                    m_tvalid    = s_tvalid[i];
                    m_tdata     = s_tdata[i*c_DW +: c_DW];
                    m_tstrb     = s_tstrb[i*c_BW +: c_BW];
                    m_tkeep     = s_tkeep[i*c_BW +: c_BW];
                    m_tlast     = s_tlast[i];
                    m_tdest     = s_tdest[i*TDEST_BITS +: TDEST_BITS];
                    m_tuser     = s_tuser[i*TUSER_BITS +: TUSER_BITS];
                    w_src_tid   = s_tid[i*TID_BITS +: TID_BITS];
                    s_tready[i] = m_tready;
                end
            end
        end
    end

`ifdef AXIS_ARB_TID_TAG_EN
    assign m_tid = (r_state == c_PASS) ? TID_BITS'(r_grant_idx) : '0;
`else
    assign m_tid = w_src_tid;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            r_grant_idx <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant_idx <= w_sel;
                        r_state     <= c_PASS;
                    end
                end
                c_PASS: begin
                    if (m_tvalid && m_tready && m_tlast) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign grant_valid = (r_state == c_PASS);
    assign grant_idx   = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_rr_arbiter
// Description : Directed self-checking bench for axis_rr_arbiter (4 sources,
//               32-bit data). Source models emit packets whose tdata encodes
//               {source, packet number, beat number, 8'h5A}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_rr_arbiter;

    localparam int NS = 4;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [NS-1:0]    s_tvalid = '0;
    logic [NS-1:0]    s_tready;
    logic [NS*32-1:0] s_tdata = '0;
    logic [NS*4-1:0]  s_tstrb = '0;
    logic [NS*4-1:0]  s_tkeep = '0;
    logic [NS-1:0]    s_tlast = '0;
    logic [NS*2-1:0]  s_tid = '0;
    logic [NS-1:0]    s_tdest = '0;
    logic [NS-1:0]    s_tuser = '0;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic [31:0]      m_tdata;
    logic [3:0]       m_tstrb;
    logic [3:0]       m_tkeep;
    logic             m_tlast;
    logic [1:0]       m_tid;
    logic [0:0]       m_tdest;
    logic [0:0]       m_tuser;
    logic             grant_valid;
    logic [1:0]       grant_idx;

    axis_rr_arbiter #(
        .NUM_SRC(4), .TDATA_BYTES(4), .TID_BITS(2), .TDEST_BITS(1), .TUSER_BITS(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Source models
    int         pk_left[NS];
    int         beat[NS];
    int         plen[NS];
    int         pk_num[NS];
    logic [1:0] tid_v[NS];

    // Beat log of master-side handshakes
    int          lg_cyc[$];
    logic [31:0] lg_data[$];
    logic        lg_last[$];
    logic [1:0]  lg_tid[$];
    logic [3:0]  lg_keep[$];
    logic [1:0]  lg_gidx[$];

    // Per-cycle snapshots
    logic       snap_mvalid[64];
    logic       snap_mlast[64];
    logic       snap_gvalid[64];
    logic [1:0] snap_gidx[64];
    logic [3:0] snap_sready[64];

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            pk_left[i] = 0; beat[i] = 0; plen[i] = 1; pk_num[i] = 0; tid_v[i] = 2'd0;
        end
    endtask

    task automatic clear_log();
        lg_cyc.delete(); lg_data.delete(); lg_last.delete();
        lg_tid.delete(); lg_keep.delete(); lg_gidx.delete();
    endtask

    task automatic drive_sources(input int c, input int drop_src, input logic [63:0] drop_mask);
        for (int i = 0; i < NS; i++) begin
            s_tvalid[i]        = (pk_left[i] > 0) && !(i == drop_src && drop_mask[c]);
            s_tdata[i*32 +: 32] = {8'(i), 8'(pk_num[i]), 8'(beat[i]), 8'h5A};
            s_tlast[i]         = (beat[i] == plen[i] - 1);
            s_tkeep[i*4 +: 4]  = 4'(i + 1);
            s_tstrb[i*4 +: 4]  = ~4'(i + 1);
            s_tid[i*2 +: 2]    = tid_v[i];
            s_tdest[i]         = 1'(i);
            s_tuser[i]         = 1'(i >> 1);
        end
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic run_cycles(input int n, input logic [63:0] rdy, input int drop_src,
                              input logic [63:0] drop_mask);
        logic [NS-1:0] hs;
        for (int c = 0; c < n; c++) begin
            drive_sources(c, drop_src, drop_mask);
            m_tready = rdy[c];
            @(negedge aclk);
            snap_mvalid[c] = m_tvalid;
            snap_mlast[c]  = m_tlast;
            snap_gvalid[c] = grant_valid;
            snap_gidx[c]   = grant_idx;
            snap_sready[c] = s_tready;
            hs = s_tvalid & s_tready;
            if (m_tvalid && m_tready) begin
                lg_cyc.push_back(c);   lg_data.push_back(m_tdata);
                lg_last.push_back(m_tlast); lg_tid.push_back(m_tid);
                lg_keep.push_back(m_tkeep); lg_gidx.push_back(grant_idx);
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (hs[i]) begin
                    if (beat[i] == plen[i] - 1) begin
                        beat[i] = 0; pk_left[i]--; pk_num[i]++;
                    end else begin
                        beat[i]++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_src();
        for (int i = 0; i < NS; i++) pk_left[i] = 1;
        aresetn = 1'b0;
        drive_sources(0, -1, '0);
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        total++; if (m_tvalid !== 1'b0)   begin bad++; $display("FAIL rst_mvalid got=%b exp=0", m_tvalid); end
        total++; if (s_tready !== 4'h0)   begin bad++; $display("FAIL rst_sready got=%h exp=0", s_tready); end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rst_gvalid got=%b exp=0", grant_valid); end
        total++; if (grant_idx !== 2'd0)  begin bad++; $display("FAIL rst_gidx got=%0d exp=0", grant_idx); end
        total++; if (m_tdata !== 32'h0)   begin bad++; $display("FAIL rst_mdata got=%h exp=0", m_tdata); end
        total++; if (m_tkeep !== 4'h0)    begin bad++; $display("FAIL rst_mkeep got=%h exp=0", m_tkeep); end
        total++; if (m_tlast !== 1'b0)    begin bad++; $display("FAIL rst_mlast got=%b exp=0", m_tlast); end
        total++; if (m_tid !== 2'd0)      begin bad++; $display("FAIL rst_mtid got=%0d exp=0", m_tid); end
    endtask

    task automatic test_rr_order();
        int es[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int ep[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        int ec[10] = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
        logic [31:0] ed;
        logic [1:0]  et;
        do_reset();
        clear_src();
        for (int i = 0; i < NS; i++) begin
            pk_left[i] = 2; plen[i] = 2; tid_v[i] = 2'(3 - i);
        end
        clear_log();
        run_cycles(15, '1, -1, '0);
        total++;
        if (lg_cyc.size() != 10) begin
            bad++; $display("FAIL rr_nbeats got=%0d exp=10", lg_cyc.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                ed = {8'(es[k]), 8'(ep[k]), 8'(k % 2), 8'h5A};
`ifdef AXIS_ARB_TID_TAG_EN
                et = 2'(es[k]);
`else
                et = 2'(3 - es[k]);
`endif
                total++; if (lg_cyc[k] != ec[k]) begin bad++; $display("FAIL rr_cyc[%0d] got=%0d exp=%0d", k, lg_cyc[k], ec[k]); end
                total++; if (lg_data[k] !== ed) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, lg_data[k], ed); end
                total++; if (lg_last[k] !== 1'(k % 2)) begin bad++; $display("FAIL rr_last[%0d] got=%b exp=%0d", k, lg_last[k], k % 2); end
                total++; if (lg_gidx[k] !== 2'(es[k])) begin bad++; $display("FAIL rr_gidx[%0d] got=%0d exp=%0d", k, lg_gidx[k], es[k]); end
                total++; if (lg_keep[k] !== 4'(es[k] + 1)) begin bad++; $display("FAIL rr_keep[%0d] got=%h exp=%h", k, lg_keep[k], 4'(es[k] + 1)); end
                total++; if (lg_tid[k] !== et) begin bad++; $display("FAIL rr_tid[%0d] got=%0d exp=%0d", k, lg_tid[k], et); end
            end
        end
    endtask

    task automatic test_single_beat();
        int ec[3] = '{1, 3, 5};
        logic [31:0] ed;
        logic [1:0]  et;
`ifdef AXIS_ARB_TID_TAG_EN
        et = 2'd2;
`else
        et = 2'd0;
`endif
        do_reset();
        clear_src();
        pk_left[2] = 3; plen[2] = 1; tid_v[2] = 2'd0;
        clear_log();
        run_cycles(7, '1, -1, '0);
        total++;
        if (lg_cyc.size() != 3) begin
            bad++; $display("FAIL sb_nbeats got=%0d exp=3", lg_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                ed = {8'd2, 8'(k), 8'd0, 8'h5A};
                total++; if (lg_cyc[k] != ec[k]) begin bad++; $display("FAIL sb_cyc[%0d] got=%0d exp=%0d", k, lg_cyc[k], ec[k]); end
                total++; if (lg_data[k] !== ed) begin bad++; $display("FAIL sb_data[%0d] got=%h exp=%h", k, lg_data[k], ed); end
                total++; if (lg_last[k] !== 1'b1) begin bad++; $display("FAIL sb_last[%0d] got=%b exp=1", k, lg_last[k]); end
                total++; if (lg_tid[k] !== et) begin bad++; $display("FAIL sb_tid[%0d] got=%0d exp=%0d", k, lg_tid[k], et); end
            end
        end
        for (int c = 0; c < 7; c++) begin
            total++;
            if ((snap_sready[c] & 4'b1011) !== 4'h0) begin
                bad++; $display("FAIL sb_other_ready[%0d] got=%h exp=0 on non-granted", c, snap_sready[c]);
            end
        end
    endtask

    task automatic test_stall_hold();
        int ec[6] = '{1, 3, 4, 8, 11, 13};
        int es[6] = '{0, 1, 1, 1, 1, 0};
        int ep[6] = '{0, 0, 0, 0, 0, 1};
        int eb[6] = '{0, 0, 1, 2, 3, 0};
        int stall[5] = '{5, 6, 7, 9, 10};
        logic [63:0] rdy;
        logic [31:0] ed;
        rdy = '1;
        for (int s = 0; s < 5; s++) rdy[stall[s]] = 1'b0;
        do_reset();
        clear_src();
        pk_left[0] = 2; plen[0] = 1;
        pk_left[1] = 1; plen[1] = 4;
        clear_log();
        run_cycles(15, rdy, -1, '0);
        total++;
        if (lg_cyc.size() != 6) begin
            bad++; $display("FAIL st_nbeats got=%0d exp=6", lg_cyc.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                ed = {8'(es[k]), 8'(ep[k]), 8'(eb[k]), 8'h5A};
                total++; if (lg_cyc[k] != ec[k]) begin bad++; $display("FAIL st_cyc[%0d] got=%0d exp=%0d", k, lg_cyc[k], ec[k]); end
                total++; if (lg_data[k] !== ed) begin bad++; $display("FAIL st_data[%0d] got=%h exp=%h", k, lg_data[k], ed); end
            end
        end
        for (int s = 0; s < 5; s++) begin
            total++; if (snap_mvalid[stall[s]] !== 1'b1) begin bad++; $display("FAIL st_mvalid[%0d] got=%b exp=1", stall[s], snap_mvalid[stall[s]]); end
            total++; if (snap_gidx[stall[s]] !== 2'd1) begin bad++; $display("FAIL st_gidx[%0d] got=%0d exp=1", stall[s], snap_gidx[stall[s]]); end
            total++; if (snap_sready[stall[s]] !== 4'h0) begin bad++; $display("FAIL st_sready[%0d] got=%h exp=0", stall[s], snap_sready[stall[s]]); end
        end
        total++; if (snap_mlast[9] !== 1'b1 || snap_gvalid[10] !== 1'b1) begin
            bad++; $display("FAIL st_tlast_hold got=last%b/gv%b exp=1/1", snap_mlast[9], snap_gvalid[10]);
        end
    endtask

    task automatic test_valid_gap();
        int ec[4] = '{1, 2, 6, 7};
        logic [63:0] drop;
        logic [31:0] ed;
        drop = '0;
        drop[3] = 1'b1; drop[4] = 1'b1; drop[5] = 1'b1;
        do_reset();
        clear_src();
        pk_left[3] = 1; plen[3] = 4;
        clear_log();
        run_cycles(9, '1, 3, drop);
        total++;
        if (lg_cyc.size() != 4) begin
            bad++; $display("FAIL gap_nbeats got=%0d exp=4", lg_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                ed = {8'd3, 8'd0, 8'(k), 8'h5A};
                total++; if (lg_cyc[k] != ec[k]) begin bad++; $display("FAIL gap_cyc[%0d] got=%0d exp=%0d", k, lg_cyc[k], ec[k]); end
                total++; if (lg_data[k] !== ed) begin bad++; $display("FAIL gap_data[%0d] got=%h exp=%h", k, lg_data[k], ed); end
                total++; if (lg_last[k] !== (k == 3)) begin bad++; $display("FAIL gap_last[%0d] got=%b exp=%0d", k, lg_last[k], k == 3); end
            end
        end
        for (int c = 3; c < 6; c++) begin
            total++; if (snap_mvalid[c] !== 1'b0) begin bad++; $display("FAIL gap_mvalid[%0d] got=%b exp=0", c, snap_mvalid[c]); end
            total++; if (snap_gidx[c] !== 2'd3 || snap_gvalid[c] !== 1'b1) begin
                bad++; $display("FAIL gap_grant[%0d] got=%0d/%b exp=3/1", c, snap_gidx[c], snap_gvalid[c]);
            end
        end
        total++; if (snap_gvalid[8] !== 1'b0) begin bad++; $display("FAIL gap_release got=%b exp=0", snap_gvalid[8]); end
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        clear_src();
        pk_left[0] = 1; plen[0] = 1;
        pk_left[1] = 1; plen[1] = 4;
        clear_log();
        run_cycles(5, '1, -1, '0);
        drive_sources(5, -1, '0);
        m_tready = 1'b1;
        #1;
        total++; if (m_tvalid !== 1'b1 || grant_idx !== 2'd1) begin
            bad++; $display("FAIL mr_pre got=v%b/g%0d exp=v1/g1", m_tvalid, grant_idx);
        end
        total++; if (m_tdata !== {8'd1, 8'd0, 8'd2, 8'h5A}) begin
            bad++; $display("FAIL mr_pre_data got=%h exp=%h", m_tdata, {8'd1, 8'd0, 8'd2, 8'h5A});
        end
        aresetn = 1'b0;
        #1;
        total++; if (m_tvalid !== 1'b0)    begin bad++; $display("FAIL mr_mvalid got=%b exp=0", m_tvalid); end
        total++; if (s_tready !== 4'h0)    begin bad++; $display("FAIL mr_sready got=%h exp=0", s_tready); end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL mr_gvalid got=%b exp=0", grant_valid); end
        total++; if (grant_idx !== 2'd0)   begin bad++; $display("FAIL mr_gidx got=%0d exp=0", grant_idx); end
        total++; if (m_tdata !== 32'h0)    begin bad++; $display("FAIL mr_mdata got=%h exp=0", m_tdata); end
        clear_src();
        for (int i = 0; i < NS; i++) begin
            pk_left[i] = 1; plen[i] = 2;
        end
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        clear_log();
        run_cycles(4, '1, -1, '0);
        total++;
        if (lg_cyc.size() < 1) begin
            bad++; $display("FAIL mr_first_nbeats got=%0d exp>=1", lg_cyc.size());
        end else begin
            total++; if (lg_cyc[0] != 1) begin bad++; $display("FAIL mr_first_cyc got=%0d exp=1", lg_cyc[0]); end
            total++; if (lg_data[0][31:24] !== 8'd0) begin bad++; $display("FAIL mr_first_src got=%0d exp=0", lg_data[0][31:24]); end
        end
    endtask

    initial begin
        clear_src();
        test_reset();
        test_rr_order();
        test_single_beat();
        test_stall_hold();
        test_valid_gap();
        test_reset_midpacket();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
